cnn_layer_accel_result_packer: RTL and testbench

CNN_LAYER_ACCEL_RESULT_PACKER -- requirements
Module: cnn_layer_accel_result_packer

---
 rtl/cnn_layer_accel_result_pkg.sv | 27 ++
 rtl/cnn_layer_accel_out_reg.sv | 59 +++++
 rtl/cnn_layer_accel_result_packer.sv | 202 ++++++++++++++++++++
 tb/tb_cnn_layer_accel_result_packer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_layer_accel_result_pkg.sv
// ============================================================================
// Module   : cnn_layer_accel_result_pkg
// Brief    : Shared types and constants for the CNN layer result packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_layer_accel_result_pkg;

    localparam int unsigned C_LANES          = 8;
    localparam int unsigned C_LANE_W         = 3;
    localparam int          C_DEF_RES_WIDTH  = 16;
    localparam int          C_DEF_PACK_WIDTH = 128;
    localparam int          C_DEF_CNT_WIDTH  = 16;

    localparam logic [C_LANE_W-1:0] C_LAST_LANE = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/cnn_layer_accel_out_reg.sv
// ============================================================================
// Module   : cnn_layer_accel_out_reg
// Brief    : Valid/ready holding register for packed words, refillable in the
//            same cycle its current word is drained.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_layer_accel_out_reg
    import cnn_layer_accel_result_pkg::*;
#(
    parameter int C_PACK_WIDTH = C_DEF_PACK_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    load_i,
    input  logic [C_PACK_WIDTH-1:0] data_i,
    input  logic [C_LANES-1:0]      keep_i,
    input  logic                    last_i,
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic [C_PACK_WIDTH-1:0] data_o,
    output logic [C_LANES-1:0]      keep_o,
    output logic                    last_o,
    output logic                    can_load_o
);

    logic                    valid_q;
    logic [C_PACK_WIDTH-1:0] data_q;
    logic [C_LANES-1:0]      keep_q;
    logic                    last_q;

    // Free when empty or when the held word leaves this cycle.
    assign can_load_o = !valid_q || ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            keep_q  <= keep_i;
            last_q  <= last_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;

endmodule

`default_nettype wire

// File: rtl/cnn_layer_accel_result_packer.sv
// ============================================================================
// Module   : cnn_layer_accel_result_packer
// Brief    : Packs a job's result samples into 8-lane words with keep/last.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_layer_accel_result_packer
    import cnn_layer_accel_result_pkg::*;
#(
    parameter int C_RES_WIDTH  = C_DEF_RES_WIDTH,
    parameter int C_PACK_WIDTH = C_DEF_PACK_WIDTH,
    parameter int C_CNT_WIDTH  = C_DEF_CNT_WIDTH
) (
    input  logic                    clk_if,
    input  logic                    rst,
    input  logic                    job_arm,
    input  logic [C_CNT_WIDTH-1:0]  expected_count,
    input  logic                    result_valid,
    output logic                    result_accept,
    input  logic [C_RES_WIDTH-1:0]  result_data,
    output logic                    pack_valid,
    input  logic                    pack_ready,
    output logic [C_PACK_WIDTH-1:0] pack_data,
    output logic [C_LANES-1:0]      pack_keep,
    output logic                    pack_last,
    output logic                    job_done,
    output logic                    arm_err
);

    state_e                  state_q, state_d;
    logic [C_CNT_WIDTH-1:0]  exp_q;
    logic [C_CNT_WIDTH-1:0]  cnt_q;
    logic [C_LANE_W-1:0]     lane_q;
    logic [C_PACK_WIDTH-1:0] acc_q;
    logic [C_LANES-1:0]      keep_q;
    logic                    acc_full_q, acc_full_d;
    logic                    acc_last_q;
    logic                    accept_q, accept_d;
    logic                    done_q, done_d;
    logic                    arm_err_q;

    logic                    w_arm_idle;
    logic                    w_xfer;
    logic                    w_final;
    logic                    w_complete;
    logic                    w_can_load;
    logic                    w_direct;
    logic                    w_park;
    logic                    w_move;
    logic                    w_out_load;
    logic [C_CNT_WIDTH:0]    w_cnt_inc;
    logic [C_PACK_WIDTH-1:0] w_word;
    logic [C_LANES-1:0]      w_keep;
    logic [C_PACK_WIDTH-1:0] w_out_data;
    logic [C_LANES-1:0]      w_out_keep;
    logic                    w_out_last;

    assign w_arm_idle = job_arm && (state_q == ST_IDLE);
    assign w_xfer     = result_valid && accept_q;

    // One bit wider than the count so an all-ones expected_count cannot wrap.
    assign w_cnt_inc  = {1'b0, cnt_q} + {{C_CNT_WIDTH{1'b0}}, 1'b1};
    assign w_final    = (w_cnt_inc == {1'b0, exp_q});
    assign w_complete = w_xfer && ((lane_q == C_LAST_LANE) || w_final);

    // A completed word goes straight out if it can, otherwise it parks in the
    // accumulator (which stalls intake) until the output register frees up.
    assign w_direct   = w_complete && w_can_load;
    assign w_park     = w_complete && !w_can_load;
    assign w_move     = acc_full_q && w_can_load;
    assign w_out_load = w_direct || w_move;

    for (genvar g = 0; g < C_LANES; g++) begin : g_lane
        assign w_word[g*C_RES_WIDTH +: C_RES_WIDTH] =
            (lane_q == C_LANE_W'(g)) ? result_data : acc_q[g*C_RES_WIDTH +: C_RES_WIDTH];
    end

    assign w_keep     = keep_q | (C_LANES'(1) << lane_q);
    assign w_out_data = w_move ? acc_q      : w_word;
    assign w_out_keep = w_move ? keep_q     : w_keep;
    assign w_out_last = w_move ? acc_last_q : w_final;

    always_comb begin
        state_d    = state_q;
        acc_full_d = acc_full_q;
        if (w_park) begin
            acc_full_d = 1'b1;
        end else if (w_move) begin
            acc_full_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (job_arm) begin
                    state_d = (expected_count == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_xfer && w_final) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pack_valid && pack_ready && pack_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Accept is registered, so it is derived from next-cycle state.
        accept_d = (state_d == ST_COLLECT) && !acc_full_d;
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            accept_q  <= 1'b0;
            done_q    <= 1'b0;
            arm_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            accept_q <= accept_d;
            done_q   <= done_d;
            if (job_arm && (state_q != ST_IDLE)) begin
                arm_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) begin
            exp_q      <= '0;
            cnt_q      <= '0;
            lane_q     <= '0;
            acc_q      <= '0;
            keep_q     <= '0;
            acc_full_q <= 1'b0;
            acc_last_q <= 1'b0;
        end else if (w_arm_idle) begin
            exp_q      <= expected_count;
            cnt_q      <= '0;
            lane_q     <= '0;
            acc_q      <= '0;
            keep_q     <= '0;
            acc_full_q <= 1'b0;
            acc_last_q <= 1'b0;
        end else begin
            acc_full_q <= acc_full_d;
            if (w_xfer) begin
                cnt_q <= w_cnt_inc[C_CNT_WIDTH-1:0];
            end
            if (w_complete) begin
                lane_q <= '0;
                if (w_can_load) begin
                    acc_q  <= '0;
                    keep_q <= '0;
                end else begin
                    acc_q      <= w_word;
                    keep_q     <= w_keep;
                    acc_last_q <= w_final;
                end
            end else if (w_xfer) begin
                lane_q <= lane_q + 1'b1;
                acc_q  <= w_word;
                keep_q <= w_keep;
            end else if (w_move) begin
                acc_q  <= '0;
                keep_q <= '0;
            end
        end
    end

    cnn_layer_accel_out_reg #(
        .C_PACK_WIDTH (C_PACK_WIDTH)
    ) u_out_reg (
        .clk_i      (clk_if),
        .rst_ni     (rst),
        .load_i     (w_out_load),
        .data_i     (w_out_data),
        .keep_i     (w_out_keep),
        .last_i     (w_out_last),
        .ready_i    (pack_ready),
        .valid_o    (pack_valid),
        .data_o     (pack_data),
        .keep_o     (pack_keep),
        .last_o     (pack_last),
        .can_load_o (w_can_load)
    );

    assign result_accept = accept_q;
    assign job_done      = done_q;
    assign arm_err       = arm_err_q;

endmodule

`default_nettype wire

// File: tb/tb_cnn_layer_accel_result_packer.sv
// ============================================================================
// Module   : tb_cnn_layer_accel_result_packer
// Brief    : Directed self-checking bench for the result packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnn_layer_accel_result_packer;

    logic         clk_if;
    logic         rst;
    logic         job_arm;
    logic [15:0]  expected_count;
    logic         result_valid;
    logic         result_accept;
    logic [15:0]  result_data;
    logic         pack_valid;
    logic         pack_ready;
    logic [127:0] pack_data;
    logic [7:0]   pack_keep;
    logic         pack_last;
    logic         job_done;
    logic         arm_err;

    int           checks;
    int           failures;
    logic [127:0] first_word;

    cnn_layer_accel_result_packer dut (
        .clk_if         (clk_if),
        .rst            (rst),
        .job_arm        (job_arm),
        .expected_count (expected_count),
        .result_valid   (result_valid),
        .result_accept  (result_accept),
        .result_data    (result_data),
        .pack_valid     (pack_valid),
        .pack_ready     (pack_ready),
        .pack_data      (pack_data),
        .pack_keep      (pack_keep),
        .pack_last      (pack_last),
        .job_done       (job_done),
        .arm_err        (arm_err)
    );

    initial clk_if = 1'b0;
    always #5 clk_if = ~clk_if;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Runs one job: arm with n, stream results base+1..base+n, consume words
    // with pack_ready low for the first 'stall' cycles. Optionally re-arms
    // mid-collect with a different count, which must be ignored.
    task automatic run_job(input int n, input int stall, input bit rearm, input int base);
        int           sent;
        int           got;
        int           exp_words;
        int           last_cyc;
        int           idx;
        bit           pend;
        bit           done_seen;
        bit           stable_ok;
        bit           had_hold;
        logic [127:0] hold_data;
        logic [127:0] exp_data;
        logic [7:0]   exp_keep;
        sent      = 0;
        got       = 0;
        exp_words = (n + 7) / 8;
        last_cyc  = 0;
        pend      = 1'b0;
        done_seen = 1'b0;
        stable_ok = 1'b1;
        had_hold  = 1'b0;
        hold_data = '0;
        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            @(negedge clk_if);
            if (pend) sent++;
            job_arm        = (cyc == 0) || (rearm && cyc == 3);
            expected_count = (cyc == 0) ? 16'(n) : 16'd5;
            result_valid   = (sent < n);
            result_data    = 16'(base + sent + 1);
            pack_ready     = (cyc >= stall);
            pend           = result_valid && result_accept;
            if (stall > 0 && cyc == stall) chk("stall_accepted", 128'(sent), 128'd16);
            if (job_done) begin
                chk("done_timing", 128'(cyc), 128'(last_cyc + 1));
                done_seen = 1'b1;
            end
            if (pack_valid && !pack_ready) begin
                if (had_hold && pack_data !== hold_data) stable_ok = 1'b0;
                hold_data = pack_data;
                had_hold  = 1'b1;
            end else begin
                had_hold = 1'b0;
            end
            if (pack_valid && pack_ready) begin
                exp_data = '0;
                exp_keep = '0;
                for (int l = 0; l < 8; l++) begin
                    idx = got * 8 + l;
                    if (idx < n) begin
                        exp_data[l*16 +: 16] = 16'(base + idx + 1);
                        exp_keep[l]          = 1'b1;
                    end
                end
                chk("word_data", pack_data, exp_data);
                chk("word_keep", 128'(pack_keep), 128'(exp_keep));
                chk("word_last", 128'(pack_last), 128'(got == exp_words - 1));
                if (got == 0) first_word = pack_data;
                if (pack_last) last_cyc = cyc;
                got++;
            end
        end
        job_arm      = 1'b0;
        result_valid = 1'b0;
        pack_ready   = 1'b1;
        chk("word_count", 128'(got), 128'(exp_words));
        chk("done_seen", 128'(done_seen), 128'd1);
        if (stall > 0) chk("stall_stable", 128'(stable_ok), 128'd1);
        @(negedge clk_if);
        chk("done_pulse_width", 128'(job_done), 128'd0);
    endtask

    task automatic reset_mid_job();
        int sent;
        int seen_valid;
        bit pend;
        sent = 0;
        pend = 1'b0;
        @(negedge clk_if);
        job_arm        = 1'b1;
        expected_count = 16'd16;
        pack_ready     = 1'b1;
        for (int c = 0; c < 50 && sent < 5; c++) begin
            @(negedge clk_if);
            if (pend) sent++;
            job_arm      = 1'b0;
            result_valid = (sent < 5);
            result_data  = 16'(sent + 1);
            pend         = result_valid && result_accept;
        end
        chk("rst_pre_sent", 128'(sent), 128'd5);
        rst = 1'b0;
        #1;
        chk("rst_accept", 128'(result_accept), 128'd0);
        chk("rst_valid", 128'(pack_valid), 128'd0);
        chk("rst_data", pack_data, 128'd0);
        chk("rst_keep", 128'(pack_keep), 128'd0);
        chk("rst_last_done_err", 128'({pack_last, job_done, arm_err}), 128'd0);
        result_valid = 1'b0;
        repeat (2) @(negedge clk_if);
        rst = 1'b1;
        seen_valid = 0;
        repeat (10) begin
            @(negedge clk_if);
            if (pack_valid || result_accept) seen_valid++;
        end
        chk("post_rst_quiet", 128'(seen_valid), 128'd0);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        first_word     = '0;
        rst            = 1'b0;
        job_arm        = 1'b0;
        expected_count = '0;
        result_valid   = 1'b0;
        result_data    = '0;
        pack_ready     = 1'b0;
        repeat (3) @(negedge clk_if);
        chk("reset_outs", 128'({result_accept, pack_valid, pack_last, job_done, arm_err}), 128'd0);
        chk("reset_data_keep", pack_data | 128'(pack_keep), 128'd0);
        rst = 1'b1;

        run_job(8, 0, 1'b0, 0);
        chk("w8_const", first_word, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("no_arm_err", 128'(arm_err), 128'd0);

        run_job(19, 0, 1'b0, 16'h0100);
        run_job(24, 20, 1'b0, 16'h0200);
        run_job(0, 0, 1'b0, 0);
        run_job(9, 0, 1'b1, 16'h0300);
        chk("arm_err_set", 128'(arm_err), 128'd1);

        reset_mid_job();
        run_job(8, 0, 1'b0, 16'h0400);
        chk("post_rst_word", first_word, 128'h0408_0407_0406_0405_0404_0403_0402_0401);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
